// File: rtl/sdram_pixel_writer_if.sv
// Write-command bus between the pixel writer and the 16-bit SDRAM controller.
// The master issues single-word writes; the slave answers with ack, then data-valid.
interface sdram_pixel_writer_if #(
    parameter int ADDR_W = 25
);
    logic              sys_cmd_wr;
    logic [ADDR_W-1:0] sys_addr;
    logic [15:0]       sys_din;
    logic              sys_ack_wr;
    logic              sys_wr_valid;

    modport master (
        output sys_cmd_wr,
        output sys_addr,
        output sys_din,
        input  sys_ack_wr,
        input  sys_wr_valid
    );

    modport slave (
        input  sys_cmd_wr,
        input  sys_addr,
        input  sys_din,
        output sys_ack_wr,
        output sys_wr_valid
    );
endinterface

// File: rtl/sdram_pixel_writer.sv
// Packs an 8-bit pixel byte stream into addressed 16-bit words, buffers them in a
// small FIFO and drains them as single-word SDRAM write commands.
module sdram_pixel_writer #(
    parameter int ADDR_W      = 25,
    parameter int FIFO_AW     = 4,
    parameter int FRAME_WORDS = 76800,
    parameter int BASE_ADDR   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  pix_valid,
    input  logic [7:0]            pix_data,
    sdram_pixel_writer_if.master  sdram,
    output logic [FIFO_AW:0]      fifo_level,
    output logic                  overflow,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int                DEPTH      = 1 << FIFO_AW;
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST       = ADDR_W'(BASE_ADDR + FRAME_WORDS - 1);
    localparam logic [FIFO_AW:0]  FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t              state;
    state_t              next_state;

    logic                phase;
    logic [7:0]          lo;
    logic [ADDR_W-1:0]   push_addr;

    logic [ADDR_W+15:0]  mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr;
    logic [FIFO_AW-1:0]  rd_ptr;
    logic [FIFO_AW:0]    count;

    logic                push_req;
    logic                push_ok;
    logic                full;
    logic                fifo_empty;
    logic                pop;
    logic                load;
    logic                cmd_wr;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         din_q;

    assign push_req   = pix_valid && phase && !frame_start;
    assign full       = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign push_ok    = push_req && !full;

    // frame_start wins over pixel data; a byte arriving with it opens the new frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase      <= 1'b0;
            lo         <= '0;
            push_addr  <= BASE;
            frame_done <= 1'b0;
        end else begin
            frame_done <= push_req && (push_addr == LAST);
            if (frame_start) begin
                push_addr <= BASE;
                phase     <= pix_valid;
                if (pix_valid)
                    lo <= pix_data;
            end else if (pix_valid) begin
                if (!phase) begin
                    lo    <= pix_data;
                    phase <= 1'b1;
                end else begin
                    phase     <= 1'b0;
                    push_addr <= (push_addr == LAST) ? BASE : push_addr + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {push_addr, pix_data, lo};
    end

    // Dropped words still advance push_addr above; here they only raise overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
            if (push_req && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (!fifo_empty) next_state = REQ;
            REQ: begin
                if (sdram.sys_ack_wr && sdram.sys_wr_valid)
                    next_state = IDLE;
                else if (sdram.sys_ack_wr)
                    next_state = DATA;
            end
            DATA: if (sdram.sys_wr_valid) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_wr = 1'b0;
        pop    = 1'b0;
        load   = 1'b0;
        case (state)
            IDLE: load = !fifo_empty;
            REQ: begin
                cmd_wr = 1'b1;
                pop    = sdram.sys_ack_wr && sdram.sys_wr_valid;
            end
            DATA: pop = sdram.sys_wr_valid;
            default: ;
        endcase
    end

    // Address and data are captured once from the FIFO head and held for the whole command
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            din_q  <= '0;
        end else if (load) begin
            {addr_q, din_q} <= mem[rd_ptr];
        end
    end

    assign sdram.sys_cmd_wr = cmd_wr;
    assign sdram.sys_addr   = addr_q;
    assign sdram.sys_din    = din_q;
    assign fifo_level       = count;
    assign busy             = !fifo_empty || (state != IDLE);

endmodule
